// File: rtl/snn_network_controller.sv
// Config loader and run sequencer for the 3-layer spiking network; run latency num_steps+2 cycles.
// Config bytes only accepted in IDLE/DONE (cfg_ready low while running, no stall memory).
module snn_network_controller #(
  parameter int CFG_BYTES = 39,
  parameter int STEP_W    = 8,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  input  logic [7:0]         cfg_data,
  output logic               cfg_ready,
  input  logic               start,
  input  logic [STEP_W-1:0]  num_steps,
  input  logic [2:0]         in_spikes,
  input  logic [2:0]         net_out_spikes,
  output logic               net_enable,
  output logic [2:0]         ext_spikes,
  output logic [215:0]       input_weights,
  output logic [95:0]        neuron_params,
  output logic               cfg_loaded,
  output logic               busy,
  output logic               done,
  output logic [3*CNT_W-1:0] spike_counts
);
  localparam int CFG_W = CFG_BYTES * 8;
  localparam int BC_W  = $clog2(CFG_BYTES);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CFG_W-1:0]        cfg_q, cfg_d;
  logic [BC_W-1:0]         byte_cnt_q, byte_cnt_d;
  logic                    loaded_q, loaded_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic [2:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic                    net_en_q, net_en_d;
  logic                    net_en_dly_q, net_en_dly_d;
  logic                    done_q, done_d;
  logic                    cfg_accept;

  assign cfg_ready     = (state_q == IDLE) || (state_q == DONE);
  assign cfg_accept    = cfg_valid && cfg_ready;
  assign busy          = (state_q == RUN) || (state_q == FLUSH);
  assign done          = done_q;
  assign cfg_loaded    = loaded_q;
  assign net_enable    = net_en_q;
  assign ext_spikes    = in_spikes & {3{net_en_q}};
  assign input_weights = cfg_q[CFG_W-1 -: 216];
  assign neuron_params = cfg_q[95:0];
  assign spike_counts  = cnt_q;

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    byte_cnt_d   = byte_cnt_q;
    loaded_d     = loaded_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    net_en_d     = net_en_q;
    net_en_dly_d = net_en_q;
    done_d       = done_q;

    if (cfg_accept) begin
      cfg_d = {cfg_q[CFG_W-9:0], cfg_data};
      if (byte_cnt_q == BC_W'(CFG_BYTES - 1)) begin
        byte_cnt_d = '0;
        loaded_d   = 1'b1;
      end else begin
        byte_cnt_d = byte_cnt_q + BC_W'(1);
        if (byte_cnt_q == '0) loaded_d = 1'b0;
      end
    end

    // Sample network output one cycle behind enable so FLUSH catches the last step
    for (int n = 0; n < 3; n++) begin
      if (net_en_dly_q && net_out_spikes[n] && (cnt_q[n] != {CNT_W{1'b1}}))
        cnt_d[n] = cnt_q[n] + CNT_W'(1);
    end

    case (state_q)
      IDLE, DONE: begin
        // Uses pre-edge loaded_q, so a same-cycle final byte does not enable start
        if (start && loaded_q) begin
          cnt_d = '0;
          if (num_steps != '0) begin
            state_d  = RUN;
            step_d   = num_steps;
            net_en_d = 1'b1;
            done_d   = 1'b0;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        step_d = step_q - STEP_W'(1);
        if (step_q == STEP_W'(1)) begin
          state_d  = FLUSH;
          net_en_d = 1'b0;
        end
      end
      FLUSH: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cfg_q        <= '0;
      byte_cnt_q   <= '0;
      loaded_q     <= 1'b0;
      step_q       <= '0;
      cnt_q        <= '0;
      net_en_q     <= 1'b0;
      net_en_dly_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      byte_cnt_q   <= byte_cnt_d;
      loaded_q     <= loaded_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      net_en_q     <= net_en_d;
      net_en_dly_q <= net_en_dly_d;
      done_q       <= done_d;
    end
  end
endmodule

// File: tb/tb_snn_network_controller.sv
// Self-checking bench: config image from accepted-byte history, run timing and spike sums from a cycle-indexed model.
module tb_snn_network_controller;
  localparam int STEP_W = 8;
  localparam int CNT_W  = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_valid;
  logic [7:0]         cfg_data;
  logic               cfg_ready;
  logic               start;
  logic [STEP_W-1:0]  num_steps;
  logic [2:0]         in_spikes;
  logic [2:0]         net_out_spikes;
  logic               net_enable;
  logic [2:0]         ext_spikes;
  logic [215:0]       input_weights;
  logic [95:0]        neuron_params;
  logic               cfg_loaded;
  logic               busy;
  logic               done;
  logic [3*CNT_W-1:0] spike_counts;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] hist[$];

  snn_network_controller #(.CFG_BYTES(39), .STEP_W(STEP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .start(start), .num_steps(num_steps),
    .in_spikes(in_spikes), .net_out_spikes(net_out_spikes),
    .net_enable(net_enable), .ext_spikes(ext_spikes),
    .input_weights(input_weights), .neuron_params(neuron_params),
    .cfg_loaded(cfg_loaded), .busy(busy), .done(done), .spike_counts(spike_counts)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected config image: the last 39 accepted bytes, oldest at the top.
  function automatic logic [311:0] exp_cfg();
    logic [311:0] v = '0;
    for (int i = 0; i < 39; i++) begin
      int idx = hist.size() - 39 + i;
      if (idx >= 0) v[311 - 8*i -: 8] = hist[idx];
    end
    return v;
  endfunction

  function automatic logic exp_loaded();
    int c = hist.size();
    return (c >= 39) && (c % 39 == 0);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hist.delete();
    tick();
  endtask

  task automatic load_bytes(input int n, input bit seq, input int base);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = seq ? 8'(base + i) : 8'($urandom);
      tick();
      hist.push_back(cfg_data);
      n_cmp++;
      if (cfg_loaded !== exp_loaded()) begin
        n_err++;
        $display("FAIL cfg_loaded after byte %0d: got %b want %b", hist.size(), cfg_loaded, exp_loaded());
      end
    end
    cfg_valid = 1'b0;
    n_cmp++;
    if ({input_weights, neuron_params} !== exp_cfg()) begin
      n_err++;
      $display("FAIL cfg_image: got %h want %h", {input_weights, neuron_params}, exp_cfg());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_valid = 1'b0; cfg_data = '0; start = 1'b0; num_steps = '0;
    in_spikes = '0; net_out_spikes = '0;
    tick();
    n_cmp++;
    if ({net_enable, busy, done, cfg_loaded, spike_counts, input_weights, neuron_params, ext_spikes} !== '0
        || cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: en=%b busy=%b done=%b loaded=%b cnt=%h rdy=%b want zeros and rdy=1",
               net_enable, busy, done, cfg_loaded, spike_counts, cfg_ready);
    end
    reset = 1'b0;
    hist.delete();
    tick();
  endtask

  task automatic test_cfg_load();
    do_reset();
    load_bytes(39, 1'b1, 1);
    n_cmp++;
    if (input_weights[215:208] !== 8'h01 || neuron_params[7:0] !== 8'h27) begin
      n_err++;
      $display("FAIL cfg_ends: got first=%h last=%h want 01 27", input_weights[215:208], neuron_params[7:0]);
    end
    load_bytes(1, 1'b0, 0);
    n_cmp++;
    if (cfg_loaded !== 1'b0) begin
      n_err++;
      $display("FAIL cfg_40th_byte: got loaded=%b want 0", cfg_loaded);
    end
  endtask

  task automatic test_start_gating();
    do_reset();
    start = 1'b1; num_steps = 8'd5;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (net_enable !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL start_unloaded cyc %0d: got en=%b done=%b busy=%b want 0 0 0", k, net_enable, done, busy);
      end
      tick();
    end
    load_bytes(39, 1'b0, 0);
  endtask

  task automatic test_zero_steps();
    start = 1'b1; num_steps = '0; net_out_spikes = 3'b111;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (done !== 1'b1 || net_enable !== 1'b0 || busy !== 1'b0 || spike_counts !== '0) begin
        n_err++;
        $display("FAIL zero_steps cyc %0d: got done=%b en=%b busy=%b cnt=%h want 1 0 0 0",
                 k, done, net_enable, busy, spike_counts);
      end
      tick();
    end
    net_out_spikes = '0;
  endtask

  // Start cycle is cycle 0; enable expected in cycles 1..n, FLUSH at n+1, done at n+2.
  // Network outputs present in cycles 2..n+1 are the ones that must be counted.
  task automatic test_run(input int n, input bit rnd, input logic [2:0] spk_fix, input logic [2:0] in_fix);
    int exp_c[3];
    logic [311:0] cfg_before;
    logic [3*CNT_W-1:0] exp_sc;
    logic exp_en;
    exp_c = '{0, 0, 0};
    cfg_before = exp_cfg();
    start = 1'b1; num_steps = STEP_W'(n);
    in_spikes = rnd ? 3'($urandom) : in_fix;
    #1;
    n_cmp++;
    if (ext_spikes !== 3'b000) begin
      n_err++;
      $display("FAIL ext_spikes_idle: got %b want 000", ext_spikes);
    end
    tick();
    start = 1'b0;
    for (int k = 1; k <= n + 2; k++) begin
      in_spikes      = rnd ? 3'($urandom) : in_fix;
      net_out_spikes = rnd ? 3'($urandom) : spk_fix;
      cfg_valid      = (k <= n + 1) ? 1'($urandom) : 1'b0;
      cfg_data       = 8'($urandom);
      #1;
      exp_en = (k <= n);
      n_cmp++;
      if (net_enable !== exp_en || busy !== (k <= n + 1) || done !== (k == n + 2)
          || cfg_ready !== (k == n + 2) || ext_spikes !== (in_spikes & {3{exp_en}})) begin
        n_err++;
        $display("FAIL run n=%0d cyc %0d: got en=%b busy=%b done=%b rdy=%b ext=%b want en=%b busy=%b done=%b rdy=%b ext=%b",
                 n, k, net_enable, busy, done, cfg_ready, ext_spikes,
                 exp_en, (k <= n + 1), (k == n + 2), (k == n + 2), in_spikes & {3{exp_en}});
      end
      if (k >= 2 && k <= n + 1)
        for (int b = 0; b < 3; b++) exp_c[b] += net_out_spikes[b];
      if (k < n + 2) tick();
    end
    cfg_valid = 1'b0;
    for (int b = 0; b < 3; b++) exp_sc[b*CNT_W +: CNT_W] = CNT_W'((exp_c[b] > 255) ? 255 : exp_c[b]);
    n_cmp++;
    if (spike_counts !== exp_sc) begin
      n_err++;
      $display("FAIL counts n=%0d: got %h want %h", n, spike_counts, exp_sc);
    end
    n_cmp++;
    if ({input_weights, neuron_params} !== cfg_before || cfg_loaded !== 1'b1) begin
      n_err++;
      $display("FAIL cfg_stable n=%0d: got loaded=%b image %h want %h", n, cfg_loaded,
               {input_weights, neuron_params}, cfg_before);
    end
    net_out_spikes = '0; in_spikes = '0;
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) test_run($urandom_range(1, 20), 1'b1, 3'b000, 3'b000);
  endtask

  task automatic test_same_cycle();
    do_reset();
    load_bytes(38, 1'b0, 0);
    cfg_valid = 1'b1; cfg_data = 8'($urandom); start = 1'b1; num_steps = 8'd3;
    tick();
    hist.push_back(cfg_data);
    cfg_valid = 1'b0; start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || net_enable !== 1'b0 || cfg_loaded !== 1'b1) begin
      n_err++;
      $display("FAIL start_with_last_byte: got busy=%b en=%b loaded=%b want 0 0 1", busy, net_enable, cfg_loaded);
    end
    cfg_valid = 1'b1; cfg_data = 8'($urandom); start = 1'b1; num_steps = 8'd2;
    tick();
    hist.push_back(cfg_data);
    cfg_valid = 1'b0; start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || net_enable !== 1'b1 || cfg_loaded !== 1'b0) begin
      n_err++;
      $display("FAIL start_with_new_load: got busy=%b en=%b loaded=%b want 1 1 0", busy, net_enable, cfg_loaded);
    end
    for (int k = 0; k < 3; k++) tick();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || {input_weights, neuron_params} !== exp_cfg()) begin
      n_err++;
      $display("FAIL same_cycle_finish: got done=%b busy=%b image %h want 1 0 %h",
               done, busy, {input_weights, neuron_params}, exp_cfg());
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    load_bytes(39, 1'b0, 0);
    start = 1'b1; num_steps = 8'd10; net_out_spikes = 3'b111;
    tick();
    start = 1'b0;
    tick(); tick();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({net_enable, busy, done, cfg_loaded, spike_counts, input_weights, neuron_params, ext_spikes} !== '0
        || cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_run: en=%b busy=%b done=%b loaded=%b cnt=%h rdy=%b want zeros and rdy=1",
               net_enable, busy, done, cfg_loaded, spike_counts, cfg_ready);
    end
    tick();
    reset = 1'b0;
    hist.delete();
    net_out_spikes = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_cfg_load();
    test_start_gating();
    test_run(5, 1'b0, 3'b101, 3'b011);
    test_zero_steps();
    test_run(255, 1'b0, 3'b111, 3'b011);
    test_run(300 % 256, 1'b0, 3'b000, 3'b011);
    test_back_to_back();
    test_same_cycle();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
